decode_issue_sb: RTL

Parametrised successor of the decode stage. It holds a valid/ready-handshaked decode output register and a per-register scoreboard with latency countdowns. Operands are resolved from an N-entry bypass array, a same-cycle RF write, or the RF read ports; an instruction is held in place while any source is not yet producible. It sits between fetch and ALU and replaces the external stall/flush-driven decode register with self-generated backpressure.

---
 rtl/decode_issue_sb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/decode_issue_sb.sv
// decode_issue_sb: decode output register with a per-register latency
// scoreboard. Operands come from the bypass array, a same-cycle RF write,
// or the RF read ports. The instruction is held at the input until every
// source can be produced.
// Optional feature: define DECODE_STALL_CNT_EN to build the saturating
// hazard-stall counter. Otherwise stall_cycles is tied to zero.
module decode_issue_sb #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYPASS = 3,
  parameter int MAX_LAT    = 7,
  localparam int AW = $clog2(NUM_REGS),
  localparam int LW = $clog2(MAX_LAT + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_pc,
  input  logic [AW-1:0]                    in_ra_addr,
  input  logic [AW-1:0]                    in_rb_addr,
  input  logic [AW-1:0]                    in_rd_addr,
  input  logic                             in_wr_en,
  input  logic [LW-1:0]                    in_lat,
  input  logic [DATA_WIDTH-1:0]            rf_ra_data,
  input  logic [DATA_WIDTH-1:0]            rf_rb_data,
  input  logic                             rf_wr_en,
  input  logic [AW-1:0]                    rf_wr_addr,
  input  logic [DATA_WIDTH-1:0]            rf_wr_data,
  input  logic [NUM_BYPASS-1:0]            byp_valid,
  input  logic [NUM_BYPASS*AW-1:0]         byp_addr,
  input  logic [NUM_BYPASS*DATA_WIDTH-1:0] byp_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_pc,
  output logic [DATA_WIDTH-1:0]            out_ra_data,
  output logic [DATA_WIDTH-1:0]            out_rb_data,
  output logic [AW-1:0]                    out_rd_addr,
  output logic                             out_wr_en,
  output logic [31:0]                      stall_cycles
);

  logic [LW-1:0]         out_lat;
  logic [NUM_REGS-1:0]   pending;
  logic [LW-1:0]         cnt [NUM_REGS];
  logic                  haz_a, haz_b;
  logic                  accept, dispatch;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;

  // The writer sitting in the output register blocks its consumers even in
  // its dispatch cycle. Its scoreboard entry only becomes visible next cycle.
  function automatic logic src_hazard(input logic [AW-1:0] s);
    logic h, byp_hit;
    byp_hit = 1'b0;
    for (int i = 0; i < NUM_BYPASS; i++)
      if (byp_valid[i] && byp_addr[i*AW +: AW] == s) byp_hit = 1'b1;
    h = out_valid && out_wr_en && (out_rd_addr == s);
    if (pending[s] && cnt[s] != '0) h = 1'b1;
    if (pending[s] && cnt[s] == '0 && !byp_hit && !(rf_wr_en && rf_wr_addr == s)) h = 1'b1;
    if (s == '0) h = 1'b0;
    return h;
  endfunction

  // Priority: r0, then the lowest-index bypass, then the RF write, then the RF read.
  function automatic logic [DATA_WIDTH-1:0] pick_operand(input logic [AW-1:0] s,
                                                         input logic [DATA_WIDTH-1:0] rf_data);
    logic [DATA_WIDTH-1:0] d;
    d = rf_data;
    if (rf_wr_en && rf_wr_addr == s) d = rf_wr_data;
    for (int i = NUM_BYPASS - 1; i >= 0; i--)
      if (byp_valid[i] && byp_addr[i*AW +: AW] == s) d = byp_data[i*DATA_WIDTH +: DATA_WIDTH];
    if (s == '0) d = '0;
    return d;
  endfunction

  // Hazard detection, operand selection and handshake generation.
  always_comb begin
    haz_a    = src_hazard(in_ra_addr);
    haz_b    = src_hazard(in_rb_addr);
    opnd_a   = pick_operand(in_ra_addr, rf_ra_data);
    opnd_b   = pick_operand(in_rb_addr, rf_rb_data);
    in_ready = reset && !flush && !haz_a && !haz_b && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    dispatch = out_valid && out_ready;
  end

  // Output register: load on accept, empty on dispatch, hold under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_ra_data <= '0;
      out_rb_data <= '0;
      out_rd_addr <= '0;
      out_wr_en   <= 1'b0;
      out_lat     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_ra_data <= opnd_a;
      out_rb_data <= opnd_b;
      out_rd_addr <= in_rd_addr;
      out_wr_en   <= in_wr_en;
      out_lat     <= in_lat;
    end else if (dispatch) begin
      out_valid <= 1'b0;
    end
  end

  // Scoreboard: set on writer dispatch (wins over the RF-write clear), count down, clear on flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      pending <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (dispatch && out_wr_en && out_rd_addr == AW'(r)) begin
          pending[r] <= 1'b1;
          cnt[r]     <= out_lat;
        end else begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - LW'(1);
          if (rf_wr_en && rf_wr_addr == AW'(r)) pending[r] <= 1'b0;
        end
      end
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count the cycles lost to operand hazards. The count saturates and only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (in_valid && !in_ready && !flush && (haz_a || haz_b) && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
